if_id_buffer: RTL and testbench

- Decoupling buffer between the instruction fetch stage and the decode stage.
- Captures each fetched {pc, instr} beat into a small in-order queue and presents the oldest entry to decode.
- Uses a valid/ready handshake so that decode stalls never drop a fetched instruction.
- Flush (branch taken / redirect) discards all queued entries; while empty, decode sees a NOP bubble.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/if_id_buffer_if.sv | 29 ++
 rtl/if_id_buffer_pipe_fifo.sv | 56 +++++
 rtl/if_id_buffer.sv | 85 ++++++++
 tb/tb_if_id_buffer.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch/decode definitions: the canonical NOP encoding and the
// layout of one buffered instruction beat.
package riscv_pkg;

    localparam int DEF_XLEN = 64;
    localparam int DEF_ILEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [DEF_XLEN-1:0] pc;
        logic [DEF_ILEN-1:0] instr;
        logic                misaligned;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_buffer_if.sv
// Fetch-side and decode-side handshake bundle of the IF/ID buffer.
// The buffer uses the slave modport; the fetch/decode side uses master.
interface if_id_buffer_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
);

    logic            in_valid_i;
    logic            in_ready_o;
    logic [XLEN-1:0] pc_i;
    logic [ILEN-1:0] instr_i;
    logic            flush_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] pc_o;
    logic [ILEN-1:0] instr_o;
    logic            misaligned_o;

    modport slave (
        input  in_valid_i, pc_i, instr_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, pc_o, instr_o, misaligned_o
    );

    modport master (
        output in_valid_i, pc_i, instr_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, pc_o, instr_o, misaligned_o
    );

endinterface

// File: rtl/if_id_buffer_pipe_fifo.sv
// Generic DEPTH-entry ring buffer with push/pop/clear, exposing the
// occupancy count and the oldest entry. DEPTH must be a power of two.
module pipe_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wr_data,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk_i) begin
        if (push && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID decoupling buffer: in-order queue of fetched {pc, instr} beats with
// flush and NOP bubbles when empty. Define IF_ID_PERF_EN for stall/drop counters.
module if_id_buffer
    import riscv_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int ILEN  = DEF_ILEN,
    parameter int DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    if_id_buffer_if.slave       bus
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0]         stall_cnt_o,
    output logic [31:0]         flush_drop_cnt_o
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = XLEN + ILEN + 1;

    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] wr_data;
    logic [ENT_W-1:0] head_data;

    // Ready looks only at the registered count, so a full buffer refuses a
    // beat even when decode drains the head in the same cycle.
    assign bus.in_ready_o  = (count != CNT_W'(DEPTH));
    assign bus.out_valid_o = (count != '0);

    assign push = bus.in_valid_i && bus.in_ready_o && !bus.flush_i;
    assign pop  = bus.out_valid_o && bus.out_ready_i && !bus.flush_i;

    assign wr_data = {bus.pc_i, bus.instr_i, (bus.pc_i[1:0] != 2'b00)};

    pipe_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (push),
        .pop       (pop),
        .clear     (bus.flush_i),
        .wr_data   (wr_data),
        .count     (count),
        .head_data (head_data)
    );

    always_comb begin
        bus.pc_o         = '0;
        bus.instr_o      = ILEN'(NOP_INSTR);
        bus.misaligned_o = 1'b0;
        if (bus.out_valid_o) begin
            bus.pc_o         = head_data[ENT_W-1 -: XLEN];
            bus.instr_o      = head_data[ILEN:1];
            bus.misaligned_o = head_data[0];
        end
    end

`ifdef IF_ID_PERF_EN
    logic [32:0] drop_sum;

    // A flush loses every queued entry plus whatever fetch offered that cycle.
    assign drop_sum = {1'b0, flush_drop_cnt_o} + 33'(count) + 33'(bus.in_valid_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o      <= '0;
            flush_drop_cnt_o <= '0;
        end else begin
            if (bus.out_valid_o && !bus.out_ready_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (bus.flush_i) begin
                flush_drop_cnt_o <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: accepted beats are queued as expected
// head entries and a negedge monitor compares them in order against the DUT.
module tb_if_id_buffer;
    import riscv_pkg::*;

    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam int DEPTH = 2;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    int checks = 0;
    int errors = 0;

    if_id_entry_t exp_q[$];

    if_id_buffer_if #(.XLEN(XLEN), .ILEN(ILEN)) bus();

`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_drop_cnt;
`endif

    if_id_buffer #(
        .XLEN  (XLEN),
        .ILEN  (ILEN),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
`ifdef IF_ID_PERF_EN
        ,
        .stall_cnt_o      (stall_cnt),
        .flush_drop_cnt_o (flush_drop_cnt)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change one time unit after the rising edge and hold for a full cycle.
    task automatic apply_stimulus(input logic v, input logic [63:0] pc, input logic [31:0] instr,
                                  input logic rdy, input logic fl);
        bus.in_valid_i  = v;
        bus.pc_i        = pc;
        bus.instr_i     = instr;
        bus.out_ready_i = rdy;
        bus.flush_i     = fl;
        @(posedge clk_i);
        #1;
    endtask

    // Recorder: every accepted beat becomes the next expected head entry.
    always @(negedge clk_i) begin
        if_id_entry_t e;
        if (rst_ni && bus.in_valid_i && bus.in_ready_o && !bus.flush_i) begin
            e.pc         = bus.pc_i;
            e.instr      = bus.instr_i;
            e.misaligned = (bus.pc_i[1:0] != 2'b00);
            #1;
            exp_q.push_back(e);
        end
    end

    // Monitor: compares the presented head with the scoreboard front.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            exp_q.delete();
        end else begin
            check_output("out_valid", 64'(bus.out_valid_o), 64'(exp_q.size() != 0));
            check_output("in_ready", 64'(bus.in_ready_o), 64'(exp_q.size() != DEPTH));
            if (bus.out_valid_o && exp_q.size() != 0) begin
                check_output("head_pc", bus.pc_o, exp_q[0].pc);
                check_output("head_instr", 64'(bus.instr_o), 64'(exp_q[0].instr));
                check_output("head_misaligned", 64'(bus.misaligned_o), 64'(exp_q[0].misaligned));
            end else if (!bus.out_valid_o) begin
                check_output("empty_pc", bus.pc_o, 64'h0);
                check_output("empty_instr", 64'(bus.instr_o), 64'(NOP_INSTR));
                check_output("empty_misaligned", 64'(bus.misaligned_o), 64'h0);
            end
            if (bus.flush_i) begin
                exp_q.delete();
            end else if (bus.out_valid_o && bus.out_ready_i && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.pc_i        = '0;
        bus.instr_i     = '0;
        bus.out_ready_i = 1'b0;
        bus.flush_i     = 1'b0;

        // Reset state
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        check_output("reset_out_valid", 64'(bus.out_valid_o), 64'h0);
        check_output("reset_in_ready", 64'(bus.in_ready_o), 64'h1);
        check_output("reset_instr", 64'(bus.instr_o), 64'h13);
        check_output("reset_pc", bus.pc_o, 64'h0);
`ifdef IF_ID_PERF_EN
        check_output("reset_drop_cnt", 64'(flush_drop_cnt), 64'h0);
`endif
        rst_ni = 1'b1;
        apply_stimulus(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);

        // Single beat passes through with one cycle of latency
        apply_stimulus(1'b1, 64'h1000, 32'h0050_0093, 1'b1, 1'b0);
        check_output("single_valid", 64'(bus.out_valid_o), 64'h1);
        check_output("single_pc", bus.pc_o, 64'h1000);
        check_output("single_instr", 64'(bus.instr_o), 64'h0050_0093);
        apply_stimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        check_output("single_drained", 64'(bus.out_valid_o), 64'h0);

        // Backpressure fills the queue; full with a pop still refuses the beat
        apply_stimulus(1'b1, 64'h1000, 32'h0010_0093, 1'b0, 1'b0);
        apply_stimulus(1'b1, 64'h1004, 32'h0020_0093, 1'b0, 1'b0);
        check_output("full_in_ready", 64'(bus.in_ready_o), 64'h0);
        apply_stimulus(1'b1, 64'h1008, 32'h0030_0093, 1'b0, 1'b0);
        check_output("stall_hold_pc", bus.pc_o, 64'h1000);
        apply_stimulus(1'b1, 64'h1008, 32'h0030_0093, 1'b1, 1'b0);
        check_output("full_pop_ready", 64'(bus.in_ready_o), 64'h1);
        check_output("full_pop_head", bus.pc_o, 64'h1004);
        apply_stimulus(1'b1, 64'h1008, 32'h0030_0093, 1'b1, 1'b0);
        check_output("late_accept_head", bus.pc_o, 64'h1008);
        apply_stimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        check_output("bp_drained", 64'(bus.out_valid_o), 64'h0);

        // Flush with two entries queued and a beat incoming
        apply_stimulus(1'b1, 64'h3000, 32'h0040_0093, 1'b0, 1'b0);
        apply_stimulus(1'b1, 64'h3004, 32'h0050_0093, 1'b0, 1'b0);
        apply_stimulus(1'b1, 64'h3008, 32'h0060_0093, 1'b0, 1'b1);
        check_output("flush_valid", 64'(bus.out_valid_o), 64'h0);
        check_output("flush_instr", 64'(bus.instr_o), 64'h13);
        check_output("flush_in_ready", 64'(bus.in_ready_o), 64'h1);
`ifdef IF_ID_PERF_EN
        check_output("flush_drop_cnt", 64'(flush_drop_cnt), 64'h3);
`endif

        // Streaming through pointer wrap, then a misaligned PC
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 64'h2000 + 64'(4 * i), 32'h0070_0093 + 32'(i), 1'b1, 1'b0);
        end
        check_output("wrap_head_pc", bus.pc_o, 64'h2010);
        apply_stimulus(1'b1, 64'h1002, 32'h0010_0113, 1'b1, 1'b0);
        apply_stimulus(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        check_output("misaligned_flag", 64'(bus.misaligned_o), 64'h1);
        check_output("misaligned_pc", bus.pc_o, 64'h1002);
        apply_stimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle with two entries queued
        apply_stimulus(1'b1, 64'h4000, 32'h0080_0093, 1'b0, 1'b0);
        apply_stimulus(1'b1, 64'h4004, 32'h0090_0093, 1'b0, 1'b0);
        bus.in_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check_output("async_rst_valid", 64'(bus.out_valid_o), 64'h0);
        check_output("async_rst_instr", 64'(bus.instr_o), 64'h13);
        check_output("async_rst_pc", bus.pc_o, 64'h0);
        check_output("async_rst_in_ready", 64'(bus.in_ready_o), 64'h1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Normal operation resumes after reset
        apply_stimulus(1'b1, 64'h5000, 32'h00A0_0093, 1'b1, 1'b0);
        check_output("post_rst_pc", bus.pc_o, 64'h5000);
        apply_stimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
